// File: rtl/regfile_sb_if.sv
// Register-file/scoreboard bus: writeback ports, issue alloc, decode read ports.
// master = pipeline side, slave = register file.
interface regfile_sb_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            w0_en;
  logic [AW-1:0]   w0_addr;
  logic [XLEN-1:0] w0_data;
  logic            w1_en;
  logic [AW-1:0]   w1_addr;
  logic [XLEN-1:0] w1_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic [AW-1:0]   r_addr1;
  logic [XLEN-1:0] r_data1;
  logic            r_rdy1;
  logic [AW-1:0]   r_addr2;
  logic [XLEN-1:0] r_data2;
  logic            r_rdy2;
  logic [AW:0]     busy_cnt;

  modport master (
    output w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           alloc_en, alloc_addr, r_addr1, r_addr2,
    input  r_data1, r_rdy1, r_data2, r_rdy2, busy_cnt
  );
  modport slave (
    input  w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           alloc_en, alloc_addr, r_addr1, r_addr2,
    output r_data1, r_rdy1, r_data2, r_rdy2, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// GPR array with dual writeback, dual combinational read and busy scoreboard.
// REGFILE_SB_BYPASS_EN enables same-cycle write-to-read forwarding.

// One architectural register plus its busy bit.
module regfile_sb_entry #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            set,
  input  logic            w0_hit,
  input  logic            w1_hit,
  input  logic [XLEN-1:0] w0_data,
  input  logic [XLEN-1:0] w1_data,
  output logic [XLEN-1:0] data_q,
  output logic            busy_q
);
  logic [XLEN-1:0] data_d;
  logic            busy_d;

  always_comb begin
    data_d = data_q;
    if (w0_hit) data_d = w0_data;
    if (w1_hit) data_d = w1_data;
    // alloc beats a same-cycle clear so the new producer stays pending
    busy_d = set ? 1'b1 : ((w0_hit || w1_hit) ? 1'b0 : busy_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end
endmodule

// NREG must equal 2**AW.
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_sb_if.slave  bus
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, set_v, w0_hit, w1_hit, dec_v;
  logic [AW:0]               busy_cnt_q, busy_cnt_d, ndec;
  logic [XLEN:0]             rp1, rp2;

  always_comb begin
    set_v  = '0;
    w0_hit = '0;
    w1_hit = '0;
    for (int i = 1; i < NREG; i++) begin
      set_v[i]  = bus.alloc_en && (bus.alloc_addr == AW'(i));
      w0_hit[i] = bus.w0_en    && (bus.w0_addr    == AW'(i));
      w1_hit[i] = bus.w1_en    && (bus.w1_addr    == AW'(i));
    end
  end

  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    regfile_sb_entry #(.XLEN(XLEN)) u_ent (
      .clk    (clk),
      .rstn   (rstn),
      .set    (set_v[g]),
      .w0_hit (w0_hit[g]),
      .w1_hit (w1_hit[g]),
      .w0_data(bus.w0_data),
      .w1_data(bus.w1_data),
      .data_q (regs[g]),
      .busy_q (busy[g])
    );
  end

  // a busy reg cleared by either/both ports drops once, unless re-allocated
  assign dec_v = (w0_hit | w1_hit) & busy & ~set_v;

  always_comb begin
    ndec = '0;
    for (int i = 0; i < NREG; i++) ndec = ndec + (AW+1)'(dec_v[i]);
    busy_cnt_d = busy_cnt_q + (AW+1)'(|(set_v & ~busy)) - ndec;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_cnt_q <= '0;
    else       busy_cnt_q <= busy_cnt_d;
  end

  function automatic logic [XLEN:0] rd_port(input logic [AW-1:0] a);
    logic [XLEN:0] r;
    r = {!busy[a], regs[a]};
`ifdef REGFILE_SB_BYPASS_EN
    if (a != '0 && bus.w1_en && bus.w1_addr == a)      r = {1'b1, bus.w1_data};
    else if (a != '0 && bus.w0_en && bus.w0_addr == a) r = {1'b1, bus.w0_data};
`endif
    if (!rstn) r = {1'b1, {XLEN{1'b0}}};
    return r;
  endfunction

  assign rp1 = rd_port(bus.r_addr1);
  assign rp2 = rd_port(bus.r_addr2);
  assign {bus.r_rdy1, bus.r_data1} = rp1;
  assign {bus.r_rdy2, bus.r_data2} = rp2;
  assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then a random phase vs a reference model.
module tb_regfile_sb;
  localparam int XLEN = 64, NREG = 32, AW = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus();
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {string tag; int kind; logic [63:0] want;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  logic [63:0] mregs [NREG];
  bit          mbusy [NREG];

  localparam logic [63:0] V3 = 64'h1234_5678_9ABC_DEF0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, want);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [63:0] want);
    exp_t e;
    e.tag = tag; e.kind = kind; e.want = want;
    sb.push_back(e);
  endtask

  task automatic expect5(input string tag, input logic [63:0] d1, input logic y1,
                         input logic [63:0] d2, input logic y2, input int cnt);
    push({tag, ".d1"}, 0, d1);
    push({tag, ".rdy1"}, 1, 64'(y1));
    push({tag, ".d2"}, 2, d2);
    push({tag, ".rdy2"}, 3, 64'(y2));
    push({tag, ".cnt"}, 4, 64'(cnt));
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] act;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = bus.r_data1;
        1:       act = 64'(bus.r_rdy1);
        2:       act = bus.r_data2;
        3:       act = 64'(bus.r_rdy2);
        default: act = 64'(bus.busy_cnt);
      endcase
      chk(e.tag, act, e.want);
    end
  endtask

  task automatic idle();
    bus.w0_en = 1'b0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_en = 1'b0; bus.w1_addr = '0; bus.w1_data = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [63:0] d);
    bus.w0_en = 1'b1; bus.w0_addr = a; bus.w0_data = d;
  endtask
  task automatic wr1(input logic [AW-1:0] a, input logic [63:0] d);
    bus.w1_en = 1'b1; bus.w1_addr = a; bus.w1_data = d;
  endtask
  task automatic alloc(input logic [AW-1:0] a);
    bus.alloc_en = 1'b1; bus.alloc_addr = a;
  endtask
  task automatic raddr(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.r_addr1 = a1; bus.r_addr2 = a2;
  endtask

  function automatic logic [64:0] mrd(input logic [AW-1:0] a);
    logic [64:0] r;
    r = (a == '0) ? {1'b1, 64'h0} : {!mbusy[a], mregs[a]};
`ifdef REGFILE_SB_BYPASS_EN
    if (a != '0 && bus.w1_en && bus.w1_addr == a)      r = {1'b1, bus.w1_data};
    else if (a != '0 && bus.w0_en && bus.w0_addr == a) r = {1'b1, bus.w0_data};
`endif
    return r;
  endfunction

  task automatic model_edge();
    bit s, c;
    for (int i = 1; i < NREG; i++) begin
      s = bus.alloc_en && bus.alloc_addr == AW'(i);
      c = (bus.w0_en && bus.w0_addr == AW'(i)) || (bus.w1_en && bus.w1_addr == AW'(i));
      mbusy[i] = s ? 1'b1 : (c ? 1'b0 : mbusy[i]);
    end
    if (bus.w0_en && bus.w0_addr != '0) mregs[bus.w0_addr] = bus.w0_data;
    if (bus.w1_en && bus.w1_addr != '0) mregs[bus.w1_addr] = bus.w1_data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [64:0] e1, e2;
    int pc;
    rstn = 1'b0;
    idle();
    raddr('0, '0);
    #12;
    expect5("rst", 0, 1, 0, 1, 0); drain();
    step(); rstn = 1'b1; step();

    // reset mid-traffic
    wr0(5'd5, 64'hDEAD); alloc(5'd7); step(); idle();
    raddr(5'd5, 5'd7);
    expect5("pre_rst", 64'hDEAD, 1, 0, 0, 1); drain();
    wr0(5'd5, 64'hBEEF); alloc(5'd9); rstn = 1'b0;
    expect5("in_rst", 0, 1, 0, 1, 0); drain();
    step(); idle(); rstn = 1'b1; step();
    raddr(5'd5, 5'd9);
    expect5("post_rst", 0, 1, 0, 1, 0); drain();

    // basic write, x0 write ignored
    wr0(5'd3, V3); step(); idle();
    wr0(5'd0, 64'hFFFF); raddr(5'd3, 5'd0);
    expect5("x3", V3, 1, 0, 1, 0); drain();
    step(); idle();
    expect5("x0", V3, 1, 0, 1, 0); drain();

    // both ports to same address: load port wins
    wr0(5'd9, 64'h11); wr1(5'd9, 64'h22); step(); idle();
    raddr(5'd9, 5'd3);
    expect5("wwprio", 64'h22, 1, V3, 1, 0); drain();

    // alloc / WAW / clear
    alloc(5'd4); step(); idle();
    raddr(5'd4, 5'd9);
    expect5("alloc4", 0, 0, 64'h22, 1, 1); drain();
    alloc(5'd4); wr0(5'd4, 64'h55);
`ifdef REGFILE_SB_BYPASS_EN
    expect5("aw4_same", 64'h55, 1, 64'h22, 1, 1);
`else
    expect5("aw4_same", 0, 0, 64'h22, 1, 1);
`endif
    drain(); step(); idle();
    expect5("aw4_next", 64'h55, 0, 64'h22, 1, 1); drain();
    wr1(5'd4, 64'h66);
`ifdef REGFILE_SB_BYPASS_EN
    expect5("w1_4_same", 64'h66, 1, 64'h22, 1, 1);
`else
    expect5("w1_4_same", 64'h55, 0, 64'h22, 1, 1);
`endif
    drain(); step(); idle();
    expect5("w1_4", 64'h66, 1, 64'h22, 1, 0); drain();

    // fill scoreboard
    for (int i = 1; i < NREG; i++) begin
      alloc(AW'(i)); step();
    end
    idle(); raddr(5'd1, 5'd31);
    expect5("all_busy", 0, 0, 0, 0, 31); drain();
    wr0(5'd1, 64'hA1); wr1(5'd2, 64'hA2); raddr(5'd1, 5'd2);
`ifdef REGFILE_SB_BYPASS_EN
    expect5("clr12_same", 64'hA1, 1, 64'hA2, 1, 31);
`else
    expect5("clr12_same", 0, 0, 0, 0, 31);
`endif
    drain(); step(); idle();
    expect5("clr12", 64'hA1, 1, 64'hA2, 1, 29); drain();
    alloc(5'd0); raddr(5'd0, 5'd3); step(); idle();
    expect5("alloc0", 0, 1, V3, 0, 29); drain();

    // load writeback to a busy register
    wr1(5'd6, 64'hABCD); raddr(5'd6, 5'd0);
`ifdef REGFILE_SB_BYPASS_EN
    expect5("byp_same", 64'hABCD, 1, 0, 1, 29);
`else
    expect5("byp_same", 0, 0, 0, 1, 29);
`endif
    drain(); step(); idle();
    expect5("byp_next", 64'hABCD, 1, 0, 1, 28); drain();

    rstn = 1'b0; raddr(5'd6, 5'd3);
    expect5("rst2", 0, 1, 0, 1, 0); drain();
    step(); rstn = 1'b1; step();
    for (int i = 0; i < NREG; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end

    // random traffic on a narrow address range to force collisions
    for (int n = 0; n < 400; n++) begin
      bus.w0_en = 1'($urandom_range(0, 1)); bus.w0_addr = AW'($urandom_range(0, 7));
      bus.w0_data = {$urandom, $urandom};
      bus.w1_en = 1'($urandom_range(0, 1)); bus.w1_addr = AW'($urandom_range(0, 7));
      bus.w1_data = {$urandom, $urandom};
      bus.alloc_en = 1'($urandom_range(0, 1)); bus.alloc_addr = AW'($urandom_range(0, 7));
      raddr(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      e1 = mrd(bus.r_addr1);
      e2 = mrd(bus.r_addr2);
      pc = 0;
      for (int i = 0; i < NREG; i++) pc += int'(mbusy[i]);
      expect5("rnd", e1[63:0], e1[64], e2[63:0], e2[64], pc);
      drain();
      model_edge();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
